reduction_correct: RTL

REDUCTION_CORRECT -- requirements
Module: reduction_correct

---
 rtl/reduction_correct_if.sv | 25 ++
 rtl/reduction_correct.sv | 137 +++++++++++++
 2 files changed

// File: rtl/reduction_correct_if.sv
// Start/operand/result bundle for the reduction-with-correction block.
interface reduction_correct_if #(
  parameter int mul_size = 80,
  parameter int radix    = 78
);
  logic                    en_reduce;
  logic [2*mul_size-1:0]   reg_a;
  logic [mul_size-1:0]     reg_m;
  logic [radix-1:0]        gamma;
  logic                    busy;
  logic                    done;
  logic [mul_size-1:0]     result;
  logic                    err_underflow;
  logic                    err_range;

  modport master (
    output en_reduce, reg_a, reg_m, gamma,
    input  busy, done, result, err_underflow, err_range
  );

  modport slave (
    input  en_reduce, reg_a, reg_m, gamma,
    output busy, done, result, err_underflow, err_range
  );
endinterface

// File: rtl/reduction_correct.sv
// Final reduction step: r = a - gamma*m (digit-serial multiply), then up to two
// conditional subtractions of m. Fixed latency radix/digit + 4 cycles.
module reduction_correct #(
  parameter int mul_size = 80,
  parameter int radix    = 78,
  parameter int digit    = 26
) (
  input  logic               clk,
  input  logic               rst_n,
  reduction_correct_if.slave bus
);
  localparam int NDIG = radix / digit;
  localparam int AW   = 2 * mul_size;
  localparam int RW   = AW + 1;
  localparam int PW   = digit + mul_size;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [2:0] {IDLE, MUL, SUB, CORR1, CORR2, DONE} state_t;

  // latched operands for the current reduction
  typedef struct packed {
    logic [AW-1:0]       a;
    logic [mul_size-1:0] m;
    logic [radix-1:0]    g;
  } op_t;

  state_t              state_q, state_d;
  op_t                 op_q;
  logic [AW-1:0]       acc_q;
  logic [CW-1:0]       cnt_q;
  logic [RW-1:0]       r_q;
  logic                uf_q;
  logic [mul_size-1:0] result_q;
  logic                eu_q, er_q;

  logic [PW-1:0]       prod;
  logic [AW-1:0]       pp;
  logic [RW-1:0]       diff;
  logic [RW-1:0]       m_ext;
  logic                r_ge_m;
  logic [RW-1:0]       r_corr;
  logic                last_dig;

  // gamma is shifted right each MUL cycle, so the active digit is always the LSBs
  assign prod     = PW'(op_q.g[digit-1:0]) * PW'(op_q.m);
  assign pp       = AW'(prod) << (digit * int'(cnt_q));
  assign diff     = {1'b0, op_q.a} - {1'b0, acc_q};
  assign m_ext    = RW'(op_q.m);
  assign r_ge_m   = (r_q >= m_ext);
  // after an underflow r is pinned at zero and corrections are bypassed
  assign r_corr   = (!uf_q && r_ge_m) ? (r_q - m_ext) : r_q;
  assign last_dig = (cnt_q == CW'(NDIG - 1));

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic; starts are only honoured in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.en_reduce) state_d = MUL;
      MUL:     if (last_dig)      state_d = SUB;
      SUB:     state_d = CORR1;
      CORR1:   state_d = CORR2;
      CORR2:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      MUL, SUB, CORR1, CORR2: bus.busy = 1'b1;
      DONE:                   bus.done = 1'b1;
      default: ;
    endcase
  end

  // datapath: operand latch, multiply-accumulate, subtract, corrections, result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      r_q      <= '0;
      uf_q     <= 1'b0;
      result_q <= '0;
      eu_q     <= 1'b0;
      er_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.en_reduce) begin
          op_q.a <= bus.reg_a;
          op_q.m <= bus.reg_m;
          op_q.g <= bus.gamma;
          acc_q  <= '0;
          cnt_q  <= '0;
          r_q    <= '0;
          uf_q   <= 1'b0;
        end
        MUL: begin
          acc_q  <= acc_q + pp;
          op_q.g <= op_q.g >> digit;
          cnt_q  <= cnt_q + 1'b1;
        end
        SUB: begin
          if (diff[RW-1]) begin
            uf_q <= 1'b1;
            r_q  <= '0;
          end else begin
            r_q  <= diff;
          end
        end
        CORR1: r_q <= r_corr;
        // second correction lands straight in the output registers so they
        // change on the same edge that raises done
        CORR2: begin
          r_q      <= r_corr;
          result_q <= r_corr[mul_size-1:0];
          eu_q     <= uf_q;
          er_q     <= (r_corr >= m_ext);
        end
        default: ;
      endcase
    end
  end

  assign bus.result        = result_q;
  assign bus.err_underflow = eu_q;
  assign bus.err_range     = er_q;
endmodule
